// File: rtl/icache_pkg.sv
// Shared refill-state encodings, AHB constants and geometry helpers for the
// N-way instruction cache.
package icache_pkg;

    localparam logic [1:0] RF_IDLE = 2'd0;
    localparam logic [1:0] RF_REQ  = 2'd1;
    localparam logic [1:0] RF_FILL = 2'd2;
    localparam logic [1:0] RF_DONE = 2'd3;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Index width that stays legal for a single-entry dimension.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int tag_bits(input int aw, input int sets, input int line_words);
        return aw - 2 - $clog2(line_words) - $clog2(sets);
    endfunction

endpackage

// File: rtl/icache_refill_fsm.sv
// Line refill sequencer: req/ack handshake, beat counting, round-robin victim
// choice per set and deferral of flushes that arrive mid-refill.
module icache_refill_fsm
    import icache_pkg::*;
#(
    parameter int AW         = 20,
    parameter int WAYS       = 4,
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4,
    localparam int WB        = $clog2(LINE_WORDS),
    localparam int IB        = $clog2(SETS),
    localparam int TW        = tag_bits(AW, SETS, LINE_WORDS),
    localparam int WYW       = idx_bits(WAYS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [AW-1:0]   start_addr,
    input  logic            flush,
    input  logic            ack,
    input  logic            valid,
    output logic            req,
    output logic [AW-1:0]   c_addr,
    output logic            fill_we,
    output logic [WYW-1:0]  fill_way,
    output logic [IB-1:0]   fill_index,
    output logic [WB-1:0]   fill_word,
    output logic [TW-1:0]   fill_tag,
    output logic            line_inval,
    output logic            line_done,
    output logic            resp_now,
    output logic            flush_now
);

    logic [1:0]     state_q, state_d;
    logic           req_q, req_d;
    logic [AW-1:0]  c_addr_q, c_addr_d;
    logic [WB-1:0]  cnt_q, cnt_d;
    logic [WYW-1:0] way_q, way_d;
    logic           flush_pend_q, flush_pend_d;
    logic [WYW-1:0] ptr_q [SETS];
    logic [WYW-1:0] ptr_d [SETS];
    logic [IB-1:0]  cur_idx_s;
    logic [IB-1:0]  start_idx_s;

    assign start_idx_s = start_addr[WB+IB+1:WB+2];
    assign cur_idx_s   = c_addr_q[WB+IB+1:WB+2];

    // Next-state, victim pointer update and per-cycle strobes.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        c_addr_d   = c_addr_q;
        cnt_d      = cnt_q;
        way_d      = way_q;
        ptr_d      = ptr_q;
        fill_we    = 1'b0;
        line_inval = 1'b0;
        line_done  = 1'b0;
        resp_now   = 1'b0;
        flush_now  = 1'b0;
        if (flush && (state_q != RF_IDLE)) begin
            flush_pend_d = 1'b1;
        end else begin
            flush_pend_d = flush_pend_q;
        end
        case (state_q)
            RF_IDLE: begin
                flush_now = flush;
                if (start) begin
                    state_d  = RF_REQ;
                    req_d    = 1'b1;
                    c_addr_d = start_addr;
                    cnt_d    = '0;
                    way_d    = ptr_q[start_idx_s];
                end else begin
                    state_d = RF_IDLE;
                end
            end
            RF_REQ: begin
                if (ack) begin
                    state_d    = RF_FILL;
                    req_d      = 1'b0;
                    line_inval = 1'b1;
                end else begin
                    req_d = 1'b1;
                end
            end
            RF_FILL: begin
                if (valid) begin
                    fill_we = 1'b1;
                    if (cnt_q == WB'(LINE_WORDS - 1)) begin
                        state_d   = RF_DONE;
                        line_done = 1'b1;
                        ptr_d[cur_idx_s] = (ptr_q[cur_idx_s] == WYW'(WAYS - 1)) ?
                                           '0 : ptr_q[cur_idx_s] + 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    state_d = RF_FILL;
                end
            end
            RF_DONE: begin
                // A deferred flush lands after the stalled read is answered.
                state_d      = RF_IDLE;
                resp_now     = 1'b1;
                flush_now    = flush_pend_q | flush;
                flush_pend_d = 1'b0;
            end
            default: begin
                state_d = RF_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // Sequencer state; reset abandons any refill in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RF_IDLE;
            req_q        <= 1'b0;
            c_addr_q     <= '0;
            cnt_q        <= '0;
            way_q        <= '0;
            flush_pend_q <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                ptr_q[s] <= '0;
            end
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            c_addr_q     <= c_addr_d;
            cnt_q        <= cnt_d;
            way_q        <= way_d;
            flush_pend_q <= flush_pend_d;
            ptr_q        <= ptr_d;
        end
    end

    assign req        = req_q;
    assign c_addr     = c_addr_q;
    assign fill_way   = way_q;
    assign fill_index = cur_idx_s;
    assign fill_word  = cnt_q;
    assign fill_tag   = c_addr_q[AW-1:AW-TW];

endmodule

// File: rtl/icache_nway.sv
// N-way set-associative read-only instruction cache with an AHB-lite slave
// port; owns lookup, hit mux, AHB response and the flop-based storage.
module icache_nway
    import icache_pkg::*;
#(
    parameter int AW         = 20,
    parameter int WAYS       = 4,
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic          hclk,
    input  logic          hreset_n,
    input  logic          hsel,
    input  logic [1:0]    htrans,
    input  logic [2:0]    hsize,
    input  logic [2:0]    hburst,
    input  logic          hwrite,
    input  logic [AW-1:0] haddr,
    input  logic [31:0]   hwdata,
    output logic [31:0]   hrdata,
    output logic          hready_out,
    output logic          hresp,
    input  logic          flush,
    output logic          req,
    output logic [AW-1:0] c_addr,
    input  logic          ack,
    input  logic          valid,
    input  logic [31:0]   data
);

    localparam int WB  = $clog2(LINE_WORDS);
    localparam int IB  = $clog2(SETS);
    localparam int TW  = tag_bits(AW, SETS, LINE_WORDS);
    localparam int WYW = idx_bits(WAYS);

    logic [TW-1:0]   tag_q  [WAYS][SETS];
    logic [TW-1:0]   tag_d  [WAYS][SETS];
    logic [SETS-1:0] vld_q  [WAYS];
    logic [SETS-1:0] vld_d  [WAYS];
    logic [31:0]     data_q [WAYS][SETS][LINE_WORDS];
    logic [31:0]     data_d [WAYS][SETS][LINE_WORDS];

    logic [31:0]     hrdata_q, hrdata_d;
    logic            hready_q, hready_d;
    logic            hresp_q, hresp_d;
    logic            err_q, err_d;
    logic [WB-1:0]   dp_word_q, dp_word_d;

    logic [WB-1:0]   a_word_s;
    logic [IB-1:0]   a_idx_s;
    logic [TW-1:0]   a_tag_s;
    logic [WAYS-1:0] match_s;
    logic [31:0]     hit_data_s;
    logic            hit_s;
    logic            accept_s;
    logic            start_s;

    logic            fill_we_s, line_inval_s, line_done_s, resp_now_s, flush_now_s;
    logic [WYW-1:0]  fill_way_s;
    logic [IB-1:0]   fill_index_s;
    logic [WB-1:0]   fill_word_s;
    logic [TW-1:0]   fill_tag_s;

    logic            unused_s;
    assign unused_s = ^{hsize, hburst, hwdata, haddr[1:0]};

    assign a_word_s = haddr[WB+1:2];
    assign a_idx_s  = haddr[WB+IB+1:WB+2];
    assign a_tag_s  = haddr[AW-1:AW-TW];
    assign accept_s = hsel && ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ)) && hready_q;

    // Parallel tag compare across all ways of the addressed set.
    always_comb begin
        match_s    = '0;
        hit_data_s = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (vld_q[w][a_idx_s] && (tag_q[w][a_idx_s] == a_tag_s)) begin
                match_s[w] = 1'b1;
                hit_data_s = hit_data_s | data_q[w][a_idx_s][a_word_s];
            end else begin
                match_s[w] = 1'b0;
            end
        end
    end
    assign hit_s = |match_s;

    // Data-phase response, computed one cycle early so outputs leave flops.
    always_comb begin
        hrdata_d  = hrdata_q;
        hready_d  = hready_q;
        hresp_d   = hresp_q;
        err_d     = 1'b0;
        dp_word_d = dp_word_q;
        start_s   = 1'b0;
        if (resp_now_s) begin
            hready_d = 1'b1;
            hresp_d  = HRESP_OKAY;
            hrdata_d = data_q[fill_way_s][fill_index_s][dp_word_q];
        end else if (err_q) begin
            hready_d = 1'b1;
            hresp_d  = HRESP_ERROR;
        end else if (accept_s) begin
            if (hwrite) begin
                hready_d = 1'b0;
                hresp_d  = HRESP_ERROR;
                err_d    = 1'b1;
            end else if (hit_s) begin
                hready_d = 1'b1;
                hresp_d  = HRESP_OKAY;
                hrdata_d = hit_data_s;
            end else begin
                hready_d  = 1'b0;
                hresp_d   = HRESP_OKAY;
                start_s   = 1'b1;
                dp_word_d = a_word_s;
            end
        end else if (hready_q) begin
            hready_d = 1'b1;
            hresp_d  = HRESP_OKAY;
        end else begin
            hready_d = 1'b0;
        end
    end

    // Storage updates: beat writes, line invalidate/commit and flush.
    always_comb begin
        vld_d  = vld_q;
        tag_d  = tag_q;
        data_d = data_q;
        if (fill_we_s) begin
            data_d[fill_way_s][fill_index_s][fill_word_s] = data;
        end else begin
            data_d = data_q;
        end
        if (flush_now_s) begin
            for (int w = 0; w < WAYS; w++) begin
                vld_d[w] = '0;
            end
        end else if (line_inval_s) begin
            vld_d[fill_way_s][fill_index_s] = 1'b0;
        end else if (line_done_s) begin
            vld_d[fill_way_s][fill_index_s] = 1'b1;
            tag_d[fill_way_s][fill_index_s] = fill_tag_s;
        end else begin
            vld_d = vld_q;
        end
    end

    // All state registers, including the storage arrays.
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            hrdata_q  <= '0;
            hready_q  <= 1'b1;
            hresp_q   <= HRESP_OKAY;
            err_q     <= 1'b0;
            dp_word_q <= '0;
            for (int w = 0; w < WAYS; w++) begin
                vld_q[w] <= '0;
                for (int s = 0; s < SETS; s++) begin
                    tag_q[w][s] <= '0;
                    for (int k = 0; k < LINE_WORDS; k++) begin
                        data_q[w][s][k] <= '0;
                    end
                end
            end
        end else begin
            hrdata_q  <= hrdata_d;
            hready_q  <= hready_d;
            hresp_q   <= hresp_d;
            err_q     <= err_d;
            dp_word_q <= dp_word_d;
            vld_q     <= vld_d;
            tag_q     <= tag_d;
            data_q    <= data_d;
        end
    end

    icache_refill_fsm #(
        .AW         (AW),
        .WAYS       (WAYS),
        .SETS       (SETS),
        .LINE_WORDS (LINE_WORDS)
    ) u_refill (
        .clk        (hclk),
        .rst_n      (hreset_n),
        .start      (start_s),
        .start_addr ({a_tag_s, a_idx_s, {(WB + 2){1'b0}}}),
        .flush      (flush),
        .ack        (ack),
        .valid      (valid),
        .req        (req),
        .c_addr     (c_addr),
        .fill_we    (fill_we_s),
        .fill_way   (fill_way_s),
        .fill_index (fill_index_s),
        .fill_word  (fill_word_s),
        .fill_tag   (fill_tag_s),
        .line_inval (line_inval_s),
        .line_done  (line_done_s),
        .resp_now   (resp_now_s),
        .flush_now  (flush_now_s)
    );

    assign hrdata     = hrdata_q;
    assign hready_out = hready_q;
    assign hresp      = hresp_q;

endmodule
